// File: rtl/led_rate_selector.sv
// led_rate_selector: debounced push-button steps a blink-rate mode; one LED
// is driven from the blink line (or constant) picked by the current mode.
module led_rate_selector #(
    parameter int g_DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    input  logic       i_Blink_10HZ,
    input  logic       i_Blink_5HZ,
    input  logic       i_Blink_2HZ,
    input  logic       i_Blink_1HZ,
    output logic       o_LED,
    output logic [2:0] o_Mode
);

    localparam int CW = (g_DEBOUNCE_LIMIT > 1) ? $clog2(g_DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(g_DEBOUNCE_LIMIT - 1);

    typedef enum logic [2:0] {
        MODE_OFF  = 3'd0,
        MODE_10HZ = 3'd1,
        MODE_5HZ  = 3'd2,
        MODE_2HZ  = 3'd3,
        MODE_1HZ  = 3'd4,
        MODE_ON   = 3'd5
    } mode_t;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] db_cnt;
    logic          stable;
    logic          stable_prev;
    logic          rel_pulse;
    mode_t         mode;
    logic          led;

    // Two-flop synchroniser, then accept a new level only after it holds LIMIT cycles
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_1      <= 1'b0;
            sync_2      <= 1'b0;
            db_cnt      <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
        end else begin
            sync_1      <= i_Switch;
            sync_2      <= sync_1;
            stable_prev <= stable;
            if (sync_2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                stable <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    // One-cycle pulse on the falling edge of the debounced level (button release)
    assign rel_pulse = stable_prev & ~stable;

    // Mode stepping on release plus registered LED mux from the current mode
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode <= MODE_OFF;
            led  <= 1'b0;
        end else begin
            if (rel_pulse) begin
                case (mode)
                    MODE_OFF:  mode <= MODE_10HZ;
                    MODE_10HZ: mode <= MODE_5HZ;
                    MODE_5HZ:  mode <= MODE_2HZ;
                    MODE_2HZ:  mode <= MODE_1HZ;
                    MODE_1HZ:  mode <= MODE_ON;
                    MODE_ON:   mode <= MODE_OFF;
                    default:   mode <= MODE_OFF;
                endcase
            end
            case (mode)
                MODE_OFF:  led <= 1'b0;
                MODE_10HZ: led <= i_Blink_10HZ;
                MODE_5HZ:  led <= i_Blink_5HZ;
                MODE_2HZ:  led <= i_Blink_2HZ;
                MODE_1HZ:  led <= i_Blink_1HZ;
                MODE_ON:   led <= 1'b1;
                default:   led <= 1'b0;
            endcase
        end
    end

    assign o_Mode = mode;
    assign o_LED  = led;

endmodule

// File: tb/tb_led_rate_selector.sv
// tb_led_rate_selector: directed scenarios for the button-driven LED rate selector.
module tb_led_rate_selector;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Switch;
    logic       i_Blink_10HZ;
    logic       i_Blink_5HZ;
    logic       i_Blink_2HZ;
    logic       i_Blink_1HZ;
    logic       o_LED;
    logic [2:0] o_Mode;

    int errors = 0;
    int checks = 0;

    led_rate_selector #(.g_DEBOUNCE_LIMIT(4)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Switch     (i_Switch),
        .i_Blink_10HZ (i_Blink_10HZ),
        .i_Blink_5HZ  (i_Blink_5HZ),
        .i_Blink_2HZ  (i_Blink_2HZ),
        .i_Blink_1HZ  (i_Blink_1HZ),
        .o_LED        (o_LED),
        .o_Mode       (o_Mode)
    );

    always #5 i_Clk = ~i_Clk;

    // one rising edge, then settle 1 time unit before sampling / driving
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic press_release(input int hold);
        i_Switch = 1'b1;
        repeat (hold) tick();
        i_Switch = 1'b0;
        repeat (hold) tick();
    endtask

    task automatic test_reset();
        i_Blink_10HZ = 1'b1; i_Blink_5HZ = 1'b1; i_Blink_2HZ = 1'b1; i_Blink_1HZ = 1'b1;
        i_Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_Switch = (i == 0);
            tick();
            checks++;
            if (o_Mode !== 3'd0 || o_LED !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d mode=%0d led=%b exp mode=0 led=0", i, o_Mode, o_LED);
            end
        end
        i_Rst = 1'b0;
        i_Switch = 1'b0;
        repeat (10) tick();
        checks++;
        if (o_Mode !== 3'd0 || o_LED !== 1'b0) begin
            errors++;
            $display("FAIL reset_after mode=%0d led=%b exp mode=0 led=0", o_Mode, o_LED);
        end
    endtask

    task automatic test_clean_latency();
        i_Blink_10HZ = 1'b1;
        i_Switch = 1'b1;
        repeat (20) tick();
        checks++;
        if (o_Mode !== 3'd0) begin
            errors++;
            $display("FAIL press_no_step mode=%0d exp=0", o_Mode);
        end
        i_Switch = 1'b0;
        repeat (6) tick();
        checks++;
        if (o_Mode !== 3'd0) begin
            errors++;
            $display("FAIL latency_early mode=%0d exp=0", o_Mode);
        end
        tick();
        checks++;
        if (o_Mode !== 3'd1) begin
            errors++;
            $display("FAIL latency_step mode=%0d exp=1", o_Mode);
        end
        checks++;
        if (o_LED !== 1'b0) begin
            errors++;
            $display("FAIL led_lag_on_step led=%b exp=0", o_LED);
        end
        tick();
        checks++;
        if (o_LED !== 1'b1) begin
            errors++;
            $display("FAIL led_after_step led=%b exp=1", o_LED);
        end
    endtask

    task automatic test_bounce();
        // bouncy press: 3-cycle pulses with 1-cycle gaps, then settled high
        for (int k = 0; k < 3; k++) begin
            i_Switch = 1'b1; repeat (3) tick();
            i_Switch = 1'b0; tick();
        end
        i_Switch = 1'b1;
        repeat (20) tick();
        checks++;
        if (o_Mode !== 3'd1) begin
            errors++;
            $display("FAIL bounce_press mode=%0d exp=1", o_Mode);
        end
        // bouncy release: glitches never reach the debounce limit
        for (int k = 0; k < 3; k++) begin
            i_Switch = 1'b0; repeat (3) tick();
            i_Switch = 1'b1; tick();
        end
        checks++;
        if (o_Mode !== 3'd1) begin
            errors++;
            $display("FAIL bounce_glitch mode=%0d exp=1", o_Mode);
        end
        i_Switch = 1'b0;
        repeat (20) tick();
        checks++;
        if (o_Mode !== 3'd2) begin
            errors++;
            $display("FAIL bounce_settle mode=%0d exp=2", o_Mode);
        end
    endtask

    task automatic test_mode_cycle();
        logic [2:0] exp_mode [6];
        logic       exp_a    [6];
        logic       exp_b    [6];
        // pattern A: 10=1 5=0 2=1 1=0 ; pattern B is its inverse
        exp_mode = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        exp_a    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_b    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        i_Rst = 1'b1; tick(); i_Rst = 1'b0;
        for (int m = 0; m < 6; m++) begin
            press_release(10);
            checks++;
            if (o_Mode !== exp_mode[m]) begin
                errors++;
                $display("FAIL cycle_mode step=%0d mode=%0d exp=%0d", m, o_Mode, exp_mode[m]);
            end
            i_Blink_10HZ = 1'b1; i_Blink_5HZ = 1'b0; i_Blink_2HZ = 1'b1; i_Blink_1HZ = 1'b0;
            tick();
            checks++;
            if (o_LED !== exp_a[m]) begin
                errors++;
                $display("FAIL cycle_led_a step=%0d led=%b exp=%b", m, o_LED, exp_a[m]);
            end
            i_Blink_10HZ = 1'b0; i_Blink_5HZ = 1'b1; i_Blink_2HZ = 1'b0; i_Blink_1HZ = 1'b1;
            tick();
            checks++;
            if (o_LED !== exp_b[m]) begin
                errors++;
                $display("FAIL cycle_led_b step=%0d led=%b exp=%b", m, o_LED, exp_b[m]);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        press_release(10);
        checks++;
        if (o_Mode !== 3'd1) begin
            errors++;
            $display("FAIL mid_pre mode=%0d exp=1", o_Mode);
        end
        i_Switch = 1'b1;
        repeat (10) tick();
        i_Switch = 1'b0;
        repeat (4) tick();  // two sync edges, then counter at 2
        i_Rst = 1'b1;
        tick();
        checks++;
        if (o_Mode !== 3'd0 || o_LED !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset mode=%0d led=%b exp mode=0 led=0", o_Mode, o_LED);
        end
        i_Rst = 1'b0;
        repeat (12) tick();
        checks++;
        if (o_Mode !== 3'd0) begin
            errors++;
            $display("FAIL mid_no_step mode=%0d exp=0", o_Mode);
        end
        press_release(10);
        checks++;
        if (o_Mode !== 3'd1) begin
            errors++;
            $display("FAIL mid_recover mode=%0d exp=1", o_Mode);
        end
    endtask

    task automatic test_blink_follow();
        logic v;
        press_release(10);
        checks++;
        if (o_Mode !== 3'd2) begin
            errors++;
            $display("FAIL follow_mode mode=%0d exp=2", o_Mode);
        end
        i_Blink_10HZ = 1'b1; i_Blink_2HZ = 1'b1; i_Blink_1HZ = 1'b1;
        v = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) v = ~v;
            i_Blink_5HZ = v;
            tick();
            checks++;
            if (o_LED !== v) begin
                errors++;
                $display("FAIL follow_5hz cyc=%0d led=%b exp=%b", i, o_LED, v);
            end
        end
    endtask

    initial begin
        i_Rst = 1'b1;
        i_Switch = 1'b0;
        i_Blink_10HZ = 1'b0; i_Blink_5HZ = 1'b0; i_Blink_2HZ = 1'b0; i_Blink_1HZ = 1'b0;
        #2;
        test_reset();
        test_clean_latency();
        test_bounce();
        test_mode_cycle();
        test_reset_mid_debounce();
        test_blink_follow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
